// File: rtl/alu_dispatch.sv
// -----------------------------------------------------------------------------
// alu_dispatch
//
// Purpose
//   Issues one command at a time to one of NUM_UNITS functional units. An
//   accepted command raises the one-hot enable of its target unit for
//   (cmd_lat + 1) cycles, after which the block returns to IDLE and emits a
//   single-cycle done pulse carrying the index of the unit that finished.
//   A new command may be accepted in the done cycle, so commands with
//   cmd_lat = 0 can be issued every other cycle.
//
// Handshake
//   cmd_valid / cmd_ready follow strict valid/ready rules: a command transfers
//   on a rising CLK edge where both are 1. cmd_ready is a pure decode of the
//   state register (high only in IDLE) and never depends on cmd_valid.
//   The producer holds cmd_sel / cmd_lat stable while cmd_valid is high;
//   whatever is presented while cmd_ready is 0 is ignored.
//
// Configuration
//   ALU_DISPATCH_ERR_EN - when defined, an accepted cmd_sel >= NUM_UNITS is
//                         rejected: err pulses for one cycle, no unit is
//                         enabled and the block stays in IDLE.
//                         When undefined, err is tied to 0 and an
//                         out-of-range select is executed on unit 0.
//
// Parameters
//   NUM_UNITS  number of functional units (2..16)
//   SEL_W      unit-select width, NUM_UNITS <= 2**SEL_W
//   LAT_W      hold-count width
//
// Ports
//   CLK          in   clock, all state changes on the rising edge
//   RST          in   synchronous active-high reset
//   cmd_valid    in   a command is offered
//   cmd_ready    out  block can accept a command (state == IDLE)
//   cmd_sel      in   [SEL_W]     target unit index
//   cmd_lat      in   [LAT_W]     extra hold cycles beyond one
//   unit_en      out  [NUM_UNITS] registered one-hot unit enables
//   busy         out  high while in EXEC
//   done         out  one-cycle completion pulse
//   done_sel     out  [SEL_W]     unit that completed, valid while done = 1
//   err          out  one-cycle out-of-range pulse (ALU_DISPATCH_ERR_EN only)
//   o_dbg_state  out  FSM state (0 = IDLE, 1 = EXEC)
//   o_dbg_cnt    out  [LAT_W]     hold counter
// -----------------------------------------------------------------------------
module alu_dispatch #(
    parameter int NUM_UNITS = 4,
    parameter int SEL_W     = 2,
    parameter int LAT_W     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [SEL_W-1:0]     cmd_sel,
    input  logic [LAT_W-1:0]     cmd_lat,
    output logic [NUM_UNITS-1:0] unit_en,
    output logic                 busy,
    output logic                 done,
    output logic [SEL_W-1:0]     done_sel,
    output logic                 err,
    output logic                 o_dbg_state,
    output logic [LAT_W-1:0]     o_dbg_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [LAT_W-1:0]     r_cnt;
    logic [SEL_W-1:0]     r_sel;
    logic [NUM_UNITS-1:0] r_unit_en;
    logic                 r_done;
    logic [SEL_W-1:0]     r_done_sel;

    // -------------------------------------------------------------------------
    // Next-state wires
    // -------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [LAT_W-1:0]     w_cnt_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [NUM_UNITS-1:0] w_unit_en_nxt;
    logic                 w_done_nxt;
    logic [SEL_W-1:0]     w_done_sel_nxt;
    logic                 w_err_nxt;

    logic                 w_accept;
    logic                 w_in_range;
    logic [SEL_W-1:0]     w_sel_eff;
    logic [NUM_UNITS-1:0] w_onehot;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Widen to 32 bits so the compare is valid for any SEL_W / NUM_UNITS pair.
    assign w_in_range = (32'(cmd_sel) < 32'(NUM_UNITS));

    // An out-of-range select that is not rejected runs on unit 0; the same
    // substituted index is what later appears on done_sel.
    assign w_sel_eff = w_in_range ? cmd_sel : '0;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_onehot[i] = (w_sel_eff == SEL_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sel_nxt      = r_sel;
        w_unit_en_nxt  = r_unit_en;
        w_done_nxt     = 1'b0;
        w_done_sel_nxt = '0;
        w_err_nxt      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_unit_en_nxt = '0;
                w_cnt_nxt     = '0;
                if (w_accept) begin
`ifdef ALU_DISPATCH_ERR_EN
                    if (w_in_range) begin
                        w_state_nxt   = ST_EXEC;
                        w_cnt_nxt     = cmd_lat;
                        w_sel_nxt     = w_sel_eff;
                        w_unit_en_nxt = w_onehot;
                    end else begin
                        // Rejected: stay in IDLE so cmd_ready remains high.
                        w_err_nxt = 1'b1;
                    end
`else
                    w_state_nxt   = ST_EXEC;
                    w_cnt_nxt     = cmd_lat;
                    w_sel_nxt     = w_sel_eff;
                    w_unit_en_nxt = w_onehot;
`endif
                end
            end

            ST_EXEC: begin
                // The counter holds the number of enable cycles still to run
                // after the current one, so zero means this is the last one.
                if (r_cnt == '0) begin
                    w_state_nxt    = ST_IDLE;
                    w_unit_en_nxt  = '0;
                    w_done_nxt     = 1'b1;
                    w_done_sel_nxt = r_sel;
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_unit_en_nxt = '0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register; reset wins over any simultaneous accept and discards an
    // in-flight command without a done pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_unit_en  <= '0;
            r_done     <= 1'b0;
            r_done_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_unit_en  <= w_unit_en_nxt;
            r_done     <= w_done_nxt;
            r_done_sel <= w_done_sel_nxt;
        end
    end

`ifdef ALU_DISPATCH_ERR_EN
    logic r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    logic w_err_unused;

    assign w_err_unused = w_err_nxt;
    assign err          = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign unit_en     = r_unit_en;
    assign busy        = (r_state == ST_EXEC);
    assign done        = r_done;
    assign done_sel    = r_done_sel;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule
